// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus interface: operation bit indices,
// FSM states, access size encoding and the operation decoder.
package lsu_pkg;

    localparam int unsigned INFO_W = 11;

    localparam int unsigned OP_LB  = 10;
    localparam int unsigned OP_LH  = 9;
    localparam int unsigned OP_LW  = 8;
    localparam int unsigned OP_LD  = 7;
    localparam int unsigned OP_LBU = 6;
    localparam int unsigned OP_LHU = 5;
    localparam int unsigned OP_LWU = 4;
    localparam int unsigned OP_SB  = 3;
    localparam int unsigned OP_SH  = 2;
    localparam int unsigned OP_SW  = 1;
    localparam int unsigned OP_SD  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // log2 of the access size in bytes
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef struct packed {
        logic  is_load;
        logic  is_store;
        logic  is_signed;
        logic  rv64_only;   // ld, lwu, sd: only legal on a 64-bit datapath
        size_e size;
    } op_t;

    function automatic op_t op_decode(input logic [INFO_W-1:0] info);
        op_t op;
        op.is_load   = |info[OP_LB:OP_LWU];
        op.is_store  = |info[OP_SB:OP_SD];
        op.is_signed = info[OP_LB] | info[OP_LH] | info[OP_LW];
        op.rv64_only = info[OP_LD] | info[OP_LWU] | info[OP_SD];
        if (info[OP_LD] | info[OP_SD])
            op.size = SZ_D;
        else if (info[OP_LW] | info[OP_LWU] | info[OP_SW])
            op.size = SZ_W;
        else if (info[OP_LH] | info[OP_LHU] | info[OP_SH])
            op.size = SZ_H;
        else
            op.size = SZ_B;
        return op;
    endfunction

endpackage

// File: rtl/lsu_bus_if_align.sv
// Combinational lane steering: store shift and strobes, load lane select with
// sign/zero extension, and the misaligned/illegal access checks.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  op_t              op,
    input  logic [2:0]       addr_lo,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  wdata_lane,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]  rdata_ext,
    output logic             misalign,
    output logic             illegal
);

    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);

    logic [OFF_W-1:0] off;
    logic [3:0]       off_ext;
    logic [3:0]       nbytes;
    logic [XLEN-1:0]  rdata_sh;

    assign off        = addr_lo[OFF_W-1:0];
    assign off_ext    = 4'(off);
    assign nbytes     = 4'd1 << op.size;
    assign wdata_lane = wdata << {off, 3'b000};
    assign rdata_sh   = rdata >> {off, 3'b000};

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_strb
            localparam logic [3:0] LANE = 4'(gi);
            assign wstrb[gi] = op.is_store && (LANE >= off_ext) && (LANE < off_ext + nbytes);
        end
    endgenerate

    // lwu is grouped with ld/sd: it only exists on a 64-bit datapath
    assign illegal  = (XLEN == 32) && op.rv64_only;
    assign misalign = (op.is_load || op.is_store) && !illegal
                      && (|(addr_lo & 3'(nbytes - 4'd1)));

    always_comb begin
        rdata_ext = rdata_sh;
        case (op.size)
            SZ_B:    rdata_ext = op.is_signed ? XLEN'($signed(rdata_sh[7:0]))  : XLEN'(rdata_sh[7:0]);
            SZ_H:    rdata_ext = op.is_signed ? XLEN'($signed(rdata_sh[15:0])) : XLEN'(rdata_sh[15:0]);
            SZ_W:    rdata_ext = op.is_signed ? XLEN'($signed(rdata_sh[31:0])) : XLEN'(rdata_sh[31:0]);
            default: rdata_ext = rdata_sh;
        endcase
    end

endmodule

// File: rtl/lsu_bus_if.sv
// Memory-stage load/store unit driving a valid/ready request/response bus;
// one access outstanding, pipeline stalled through busy while in flight.
module lsu_bus_if
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [INFO_W-1:0]   req_load_store_info,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_misalign,
    output logic                rsp_illegal,
    output logic                busy,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic                bus_req_we,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic [XLEN-1:0]     bus_req_wdata,
    output logic [XLEN/8-1:0]   bus_req_wstrb,
    input  logic                bus_rsp_valid,
    input  logic [XLEN-1:0]     bus_rsp_rdata
);

    localparam int LANES = XLEN / 8;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(LANES - 1);

    state_e            state_reg, state_next;
    op_t               op_reg;
    logic [2:0]        addr_lo_reg;
    logic [XLEN-1:0]   rdata_reg;
    logic              misalign_reg, illegal_reg, busy_reg;
    logic [ADDR_W-1:0] bus_addr_reg;
    logic [XLEN-1:0]   bus_wdata_reg;
    logic [LANES-1:0]  bus_wstrb_reg;
    logic              bus_we_reg;

    op_t               req_op, cur_op;
    logic [2:0]        cur_addr_lo;
    logic              req_fire;
    logic [XLEN-1:0]   wdata_lane, rdata_ext;
    logic [LANES-1:0]  wstrb;
    logic              misalign, illegal;

    assign req_op   = op_decode(req_load_store_info);
    assign req_fire = req_valid && (state_reg == IDLE);

    // Checks run on the incoming request while idle; load formatting uses the latched op
    assign cur_op      = (state_reg == IDLE) ? req_op : op_reg;
    assign cur_addr_lo = (state_reg == IDLE) ? req_addr[2:0] : addr_lo_reg;

    lsu_align #(.XLEN(XLEN)) u_align (
        .op         (cur_op),
        .addr_lo    (cur_addr_lo),
        .wdata      (req_wdata),
        .rdata      (bus_rsp_rdata),
        .wdata_lane (wdata_lane),
        .wstrb      (wstrb),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign),
        .illegal    (illegal)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (!(req_op.is_load || req_op.is_store) || misalign || illegal)
                        state_next = DONE;
                    else
                        state_next = REQ;
                end
            end
            REQ:     if (bus_req_ready) state_next = WAIT;
            WAIT:    if (bus_rsp_valid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            op_reg        <= '0;
            addr_lo_reg   <= '0;
            rdata_reg     <= '0;
            misalign_reg  <= 1'b0;
            illegal_reg   <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_wstrb_reg <= '0;
            bus_we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            if (req_fire) begin
                op_reg        <= req_op;
                addr_lo_reg   <= req_addr[2:0];
                rdata_reg     <= '0;
                misalign_reg  <= misalign;
                illegal_reg   <= illegal;
                bus_addr_reg  <= req_addr & ADDR_MASK;
                bus_wdata_reg <= wdata_lane;
                bus_wstrb_reg <= wstrb;
                bus_we_reg    <= req_op.is_store;
            end
            if ((state_reg == WAIT) && bus_rsp_valid && op_reg.is_load)
                rdata_reg <= rdata_ext;
        end
    end

    assign req_ready     = (state_reg == IDLE);
    assign busy          = busy_reg;
    assign bus_req_valid = (state_reg == REQ);
    assign bus_req_we    = bus_we_reg;
    assign bus_req_addr  = bus_addr_reg;
    assign bus_req_wdata = bus_wdata_reg;
    assign bus_req_wstrb = bus_wstrb_reg;
    assign rsp_valid     = (state_reg == DONE);
    assign rsp_rdata     = (state_reg == DONE) ? rdata_reg : '0;
    assign rsp_misalign  = (state_reg == DONE) && misalign_reg;
    assign rsp_illegal   = (state_reg == DONE) && illegal_reg;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if: a 64-bit and a 32-bit instance share stimulus; results
// are checked against a size/offset arithmetic model of the access rules.
module tb_lsu_bus_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        use32 = 1'b0;
    logic        req_valid = 1'b0;
    logic [10:0] info = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        bus_req_ready = 1'b0;
    logic        bus_rsp_valid = 1'b0;
    logic [63:0] bus_rsp_rdata = '0;

    logic        rv64, rv32, rr64, rr32, rm64, rm32, ri64, ri32, bz64, bz32;
    logic        bv64, bv32, we64, we32;
    logic [63:0] rd64, ba64, ba32, bw64;
    logic [31:0] rd32, bw32;
    logic [7:0]  bs64;
    logic [3:0]  bs32;

    always #5 clk = ~clk;

    lsu_bus_if #(.XLEN(64), .ADDR_W(64)) dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid && !use32), .req_ready(rr64),
        .req_load_store_info(info), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv64), .rsp_rdata(rd64), .rsp_misalign(rm64), .rsp_illegal(ri64),
        .busy(bz64), .bus_req_valid(bv64), .bus_req_ready(bus_req_ready), .bus_req_we(we64),
        .bus_req_addr(ba64), .bus_req_wdata(bw64), .bus_req_wstrb(bs64),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
    );

    lsu_bus_if #(.XLEN(32), .ADDR_W(64)) dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid && use32), .req_ready(rr32),
        .req_load_store_info(info), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_misalign(rm32), .rsp_illegal(ri32),
        .busy(bz32), .bus_req_valid(bv32), .bus_req_ready(bus_req_ready), .bus_req_we(we32),
        .bus_req_addr(ba32), .bus_req_wdata(bw32), .bus_req_wstrb(bs32),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata[31:0])
    );

    // Observed view of whichever instance is selected
    logic        o_req_ready, o_rsp_valid, o_misalign, o_illegal, o_busy, o_bus_valid, o_we;
    logic [63:0] o_rdata, o_addr, o_wdata, o_wstrb;
    assign o_req_ready = use32 ? rr32 : rr64;
    assign o_rsp_valid = use32 ? rv32 : rv64;
    assign o_misalign  = use32 ? rm32 : rm64;
    assign o_illegal   = use32 ? ri32 : ri64;
    assign o_busy      = use32 ? bz32 : bz64;
    assign o_bus_valid = use32 ? bv32 : bv64;
    assign o_we        = use32 ? we32 : we64;
    assign o_rdata     = use32 ? {32'b0, rd32} : rd64;
    assign o_addr      = use32 ? ba32 : ba64;
    assign o_wdata     = use32 ? {32'b0, bw32} : bw64;
    assign o_wstrb     = use32 ? {60'b0, bs32} : {56'b0, bs64};

    int total = 0;
    int bad   = 0;
    logic [63:0] last_rdata, last_wdata, last_wstrb, last_addr;

    // access size in bytes, indexed by req_load_store_info bit
    int sz_tab [11] = '{8, 4, 2, 1, 4, 2, 1, 8, 4, 2, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (req_valid) begin
            assert ($onehot0(info)) else begin
                bad++;
                $error("FAIL onehot observed=%b expected=at most one bit", info);
            end
        end
    end

    // One complete operation. opi = -1 is a no-op, else the info bit index.
    task automatic do_op(input bit x32, input int opi, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] mem,
                         input int rlat, input int slat);
        int          xb, size, o;
        bit          is_ld, sgn, ill, mis, skip_bus;
        logic [63:0] xmask, fmask, field, exp_rd, exp_wd, exp_strb, exp_addr;

        xb    = x32 ? 4 : 8;
        xmask = x32 ? 64'hFFFF_FFFF : '1;
        size  = (opi < 0) ? 1 : sz_tab[opi];
        is_ld = (opi >= 4);
        sgn   = (opi >= 8);
        ill   = (opi >= 0) && x32 && (opi == 7 || opi == 4 || opi == 0);
        mis   = (opi >= 0) && !ill && ((int'(addr[2:0]) % size) != 0);
        skip_bus = (opi < 0) || ill || mis;

        o        = int'(addr[2:0]) & (xb - 1);
        exp_addr = addr & ~64'(xb - 1);
        exp_wd   = (wd << (8 * o)) & xmask;
        exp_strb = 64'((((1 << size) - 1) << o) & ((1 << xb) - 1));
        fmask    = (size == 8) ? '1 : ((64'd1 << (8 * size)) - 64'd1);
        field    = ((mem & xmask) >> (8 * o)) & fmask;
        if (sgn && field[8 * size - 1]) field = field | ~fmask;
        exp_rd   = (is_ld && !skip_bus) ? (field & xmask) : 64'd0;

        @(negedge clk);
        use32     = x32;
        req_valid = 1'b1;
        info      = (opi < 0) ? 11'd0 : (11'd1 << opi);
        req_addr  = addr;
        req_wdata = wd;
        chk("req_ready_idle", 64'(o_req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        info      = '0;
        req_wdata = {$urandom, $urandom};
        chk("busy_after_hs", 64'(o_busy), 64'd1);
        chk("req_ready_low", 64'(o_req_ready), 64'd0);

        if (!skip_bus) begin
            for (int i = 0; i <= rlat; i++) begin
                chk("bus_valid", 64'(o_bus_valid), 64'd1);
                chk("bus_addr", o_addr, exp_addr);
                chk("bus_we", 64'(o_we), 64'(!is_ld));
                if (!is_ld) begin
                    chk("bus_wdata", o_wdata, exp_wd);
                    chk("bus_wstrb", o_wstrb, exp_strb);
                end
                chk("rsp_early_req", 64'(o_rsp_valid), 64'd0);
                last_wdata = o_wdata;
                last_wstrb = o_wstrb;
                last_addr  = o_addr;
                if (i == rlat) bus_req_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bus_req_ready = 1'b0;
            end
            for (int j = 0; j <= slat; j++) begin
                chk("bus_valid_wait", 64'(o_bus_valid), 64'd0);
                chk("rsp_early_wait", 64'(o_rsp_valid), 64'd0);
                chk("busy_wait", 64'(o_busy), 64'd1);
                if (j == slat) begin
                    bus_rsp_valid = 1'b1;
                    bus_rsp_rdata = mem;
                end
                @(posedge clk);
                @(negedge clk);
                bus_rsp_valid = 1'b0;
                bus_rsp_rdata = {$urandom, $urandom};
            end
        end else begin
            chk("no_bus_req", 64'(o_bus_valid), 64'd0);
        end

        chk("rsp_valid", 64'(o_rsp_valid), 64'd1);
        chk("rsp_rdata", o_rdata, exp_rd);
        chk("rsp_misalign", 64'(o_misalign), 64'(mis));
        chk("rsp_illegal", 64'(o_illegal), 64'(ill));
        last_rdata = o_rdata;
        @(posedge clk);
        @(negedge clk);
        chk("rsp_one_cycle", 64'(o_rsp_valid), 64'd0);
        chk("req_ready_back", 64'(o_req_ready), 64'd1);
        chk("busy_clear", 64'(o_busy), 64'd0);
        chk("bus_idle", 64'(o_bus_valid), 64'd0);
        $display("op x32=%0d opi=%0d addr=%h rlat=%0d slat=%0d rdata=%h mis=%0d ill=%0d",
                 x32, opi, addr, rlat, slat, last_rdata, mis, ill);
    endtask

    initial begin
        int          opi, size;
        logic [63:0] addr;

        repeat (2) @(negedge clk);
        chk("rst_req_ready64", 64'(rr64), 64'd1);
        chk("rst_rsp_valid64", 64'(rv64), 64'd0);
        chk("rst_busy64", 64'(bz64), 64'd0);
        chk("rst_bus_valid64", 64'(bv64), 64'd0);
        chk("rst_we64", 64'(we64), 64'd0);
        chk("rst_addr64", ba64, 64'd0);
        chk("rst_wdata64", bw64, 64'd0);
        chk("rst_wstrb64", 64'(bs64), 64'd0);
        chk("rst_rdata64", rd64, 64'd0);
        chk("rst_flags64", {62'd0, rm64, ri64}, 64'd0);
        chk("rst_req_ready32", 64'(rr32), 64'd1);
        chk("rst_busy32", 64'(bz32), 64'd0);
        rst = 1'b0;

        // Directed cases
        do_op(0, 10, 64'h8000_0003, 64'd0, 64'h1122_3344_8566_7788, 0, 0);
        chk("lb_const", last_rdata, 64'hFFFF_FFFF_FFFF_FF85);
        do_op(0, 6, 64'h8000_0003, 64'd0, 64'h1122_3344_8566_7788, 0, 0);
        chk("lbu_const", last_rdata, 64'h85);
        do_op(0, 2, 64'h8000_0006, 64'hABCD, 64'd0, 0, 0);
        chk("sh_addr_const", last_addr, 64'h8000_0000);
        chk("sh_wdata_const", last_wdata, 64'hABCD_0000_0000_0000);
        chk("sh_wstrb_const", last_wstrb, 64'hC0);
        do_op(0, 8, 64'h8000_0002, 64'd0, 64'd0, 0, 0);
        do_op(0, -1, 64'h1234, 64'd0, 64'd0, 0, 0);
        do_op(0, 8, 64'h8000_0010, 64'd0, 64'hDEAD_BEEF_F00D_CAFE, 5, 3);
        do_op(0, 7, 64'h8000_0008, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 1);
        do_op(0, 0, 64'h8000_0008, 64'hFEDC_BA98_7654_3210, 64'd0, 0, 2);

        // Reset pulse while waiting for the bus response
        @(negedge clk);
        use32 = 1'b0;
        req_valid = 1'b1;
        info = 11'd1 << 8;
        req_addr = 64'h100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        info = '0;
        bus_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_req_ready = 1'b0;
        chk("rstmid_busy_before", 64'(bz64), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_bus_valid", 64'(bv64), 64'd0);
        chk("rstmid_req_ready", 64'(rr64), 64'd1);
        chk("rstmid_busy", 64'(bz64), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 64'h5555_5555_5555_5555;
        @(posedge clk);
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        chk("late_rsp_ignored", 64'(rv64), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("late_rsp_ignored2", 64'(rv64), 64'd0);
        chk("late_rsp_ready", 64'(rr64), 64'd1);
        do_op(0, 9, 64'h8000_0042, 64'd0, 64'h0000_0000_9ABC_0000, 0, 0);

        // 32-bit datapath
        do_op(1, 7, 64'h0, 64'd0, 64'd0, 0, 0);
        do_op(1, 8, 64'h4, 64'd0, 64'h0000_0000_8000_0001, 0, 0);
        chk("lw32_const", last_rdata, 64'h8000_0001);
        do_op(1, 4, 64'h6, 64'd0, 64'd0, 0, 0);
        do_op(1, 2, 64'h2, 64'h1234_5678, 64'd0, 1, 0);

        // Randomised operations on both widths
        for (int n = 0; n < 60; n++) begin
            opi  = int'($urandom_range(0, 11)) - 1;
            size = (opi < 0) ? 1 : sz_tab[opi];
            addr = {32'h8000_0000, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(size - 1);
            do_op(n[0], opi, addr, {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
